// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared encodings and types for the writeback port arbiter
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;

    // memToReg source select; 2'b11 writes zero
    localparam logic [1:0] WB_SEL_ALU   = 2'b00;
    localparam logic [1:0] WB_SEL_MEM   = 2'b01;
    localparam logic [1:0] WB_SEL_PCIMM = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arbState_e;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - MCU result FIFO with per-entry live bits, kill-by-rd and pending bitmap
//   clk, rst_n          clock, asynchronous active-low reset
//   push/pushRd/pushData enqueue an MCU result (ignored when full)
//   pop                  dequeue the head (ignored when empty)
//   kill/killRd          clear live on every entry targeting killRd
//   headRd/headData/headLive  current head entry
//   count/empty/full     occupancy
//   pendBusy             one-hot OR of rd over live entries
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] pushRd,
    input  logic [XLEN-1:0]       pushData,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [REG_ADDR_W-1:0] killRd,
    output logic [REG_ADDR_W-1:0] headRd,
    output logic [XLEN-1:0]       headData,
    output logic                  headLive,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic [31:0]           pendBusy
);

    logic [REG_ADDR_W-1:0] rdMem   [DEPTH];
    logic [XLEN-1:0]       dataMem [DEPTH];
    logic [DEPTH-1:0]      liveMem;
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic                  pushEn;
    logic                  popEn;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign pushEn = push & ~full;
    assign popEn  = pop & ~empty;

    assign headRd   = rdMem[rdPtr];
    assign headData = dataMem[rdPtr];
    assign headLive = liveMem[rdPtr];

    // Payload storage needs no reset: an entry is only meaningful while live.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            rdMem[wrPtr]   <= pushRd;
            dataMem[wrPtr] <= pushData;
        end
    end

    // Popped slots drop their live bit so pendBusy needs no occupancy mask.
    // The push write comes last so a same-cycle kill never hits the new entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            liveMem <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && rdMem[i] == killRd) begin
                    liveMem[i] <= 1'b0;
                end
            end
            if (popEn) begin
                liveMem[rdPtr] <= 1'b0;
                rdPtr          <= rdPtr + 1'b1;
            end
            if (pushEn) begin
                liveMem[wrPtr] <= (pushRd != '0);
                wrPtr          <= wrPtr + 1'b1;
            end
            if (pushEn && !popEn) begin
                count <= count + 1'b1;
            end else if (popEn && !pushEn) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        pendBusy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (liveMem[i]) begin
                pendBusy[rdMem[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between pipeline writeback and MCU results
//   clk, rst_n                      clock, asynchronous active-low reset
//   pipeValid/pipeRegWrite/pipeRd   WB stage instruction
//   memToReg, Y, rdDataMem, PC_Plus_Immediate  pipeline write data sources
//   mcuValid/mcuRd/mcuData, mcuReady           MCU result handshake
//   stallPipe                       one-cycle freeze while a starved MCU result is forced out
//   regWrite/regWrtAddr/regWrtData  registered register-file write port
//   mcuPendBusy                     destinations with a live buffered MCU result
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipeValid,
    input  logic                  pipeRegWrite,
    input  logic [REG_ADDR_W-1:0] pipeRd,
    input  logic [1:0]            memToReg,
    input  logic [XLEN-1:0]       Y,
    input  logic [XLEN-1:0]       rdDataMem,
    input  logic [XLEN-1:0]       PC_Plus_Immediate,
    input  logic                  mcuValid,
    output logic                  mcuReady,
    input  logic [REG_ADDR_W-1:0] mcuRd,
    input  logic [XLEN-1:0]       mcuData,
    output logic                  stallPipe,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] regWrtAddr,
    output logic [XLEN-1:0]       regWrtData,
    output logic [31:0]           mcuPendBusy
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arbState_e             state;
    arbState_e             stateNext;
    logic [WAIT_W-1:0]     waitCnt;
    logic                  pipeClaim;
    logic                  pushEn;
    logic                  popEn;
    logic                  killEn;
    logic                  lastOut;
    logic [XLEN-1:0]       pipeData;
    logic                  wrEn;
    logic [REG_ADDR_W-1:0] wrAddr;
    logic [XLEN-1:0]       wrData;
    logic [REG_ADDR_W-1:0] headRd;
    logic [XLEN-1:0]       headData;
    logic                  headLive;
    logic [CNT_W-1:0]      fifoCount;
    logic                  fifoEmpty;
    logic                  fifoFull;

    assign stallPipe = (state == FORCE);
    assign mcuReady  = ~fifoFull;

    // During FORCE the WB stage is frozen, so its inputs neither claim nor kill.
    assign pipeClaim = pipeValid & pipeRegWrite & ~stallPipe;
    assign killEn    = pipeClaim & (pipeRd != '0);
    assign pushEn    = mcuValid & mcuReady;
    assign popEn     = ~fifoEmpty & (stallPipe | ~pipeClaim);
    assign lastOut   = popEn & ~pushEn & (fifoCount == CNT_W'(1));

    always_comb begin
        pipeData = '0;
        unique case (memToReg)
            WB_SEL_ALU:   pipeData = Y;
            WB_SEL_MEM:   pipeData = rdDataMem;
            WB_SEL_PCIMM: pipeData = PC_Plus_Immediate;
            default:      pipeData = '0;
        endcase
    end

    // rd=0 pipeline writes still own the slot; a dead head is consumed silently.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = pipeRd;
        wrData = pipeData;
        if (pipeClaim) begin
            wrEn = (pipeRd != '0);
        end else if (popEn) begin
            wrEn   = headLive;
            wrAddr = headRd;
            wrData = headData;
        end
    end

    wb_result_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (pushEn),
        .pushRd   (mcuRd),
        .pushData (mcuData),
        .pop      (popEn),
        .kill     (killEn),
        .killRd   (pipeRd),
        .headRd   (headRd),
        .headData (headData),
        .headLive (headLive),
        .count    (fifoCount),
        .empty    (fifoEmpty),
        .full     (fifoFull),
        .pendBusy (mcuPendBusy)
    );

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (pushEn) begin
                    stateNext = PEND;
                end
            end
            PEND: begin
                if (lastOut) begin
                    stateNext = IDLE;
                end else if (!popEn && waitCnt == WAIT_MAX) begin
                    stateNext = FORCE;
                end
            end
            FORCE: begin
                stateNext = lastOut ? IDLE : PEND;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            waitCnt    <= '0;
            regWrite   <= 1'b0;
            regWrtAddr <= '0;
            regWrtData <= '0;
        end else begin
            state    <= stateNext;
            regWrite <= wrEn;
            if (wrEn) begin
                regWrtAddr <= wrAddr;
                regWrtData <= wrData;
            end
            if (!fifoEmpty && !popEn) begin
                if (waitCnt != WAIT_MAX) begin
                    waitCnt <= waitCnt + 1'b1;
                end
            end else begin
                waitCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized and directed bench against a queue-based writeback model
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pipeValid, pipeRegWrite;
    logic [4:0]      pipeRd;
    logic [1:0]      memToReg;
    logic [XLEN-1:0] Y, rdDataMem, PC_Plus_Immediate;
    logic            mcuValid, mcuReady;
    logic [4:0]      mcuRd;
    logic [XLEN-1:0] mcuData;
    logic            stallPipe, regWrite;
    logic [4:0]      regWrtAddr;
    logic [XLEN-1:0] regWrtData;
    logic [31:0]     mcuPendBusy;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipeValid(pipeValid), .pipeRegWrite(pipeRegWrite), .pipeRd(pipeRd),
        .memToReg(memToReg), .Y(Y), .rdDataMem(rdDataMem),
        .PC_Plus_Immediate(PC_Plus_Immediate),
        .mcuValid(mcuValid), .mcuReady(mcuReady), .mcuRd(mcuRd), .mcuData(mcuData),
        .stallPipe(stallPipe), .regWrite(regWrite), .regWrtAddr(regWrtAddr),
        .regWrtData(regWrtData), .mcuPendBusy(mcuPendBusy)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        live;
    } ent_t;

    ent_t        mq[$];
    bit          mForce;
    int          mWait;
    logic        mWe;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    logic [31:0] dutRf [32];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelPend();
        logic [31:0] b = '0;
        foreach (mq[i]) if (mq[i].live) b[mq[i].rd] = 1'b1;
        return b;
    endfunction

    task automatic modelReset();
        mq.delete();
        mForce = 0;
        mWait  = 0;
        mWe    = 1'b0;
        mAddr  = '0;
        mData  = '0;
    endtask

    // One clock: check state-derived outputs, advance the model on the current
    // inputs, then check the registered write port after the edge.
    task automatic step();
        bit          claim, push, pop, nonEmpty, nextForce;
        logic [31:0] pdata;
        #1;
        checkEq("stallPipe", stallPipe, mForce);
        checkEq("mcuReady", mcuReady, mq.size() != DEPTH);
        checkEq("mcuPendBusy", mcuPendBusy, modelPend());
        claim    = pipeValid && pipeRegWrite && !mForce;
        push     = mcuValid && (mq.size() != DEPTH);
        nonEmpty = mq.size() != 0;
        pop      = nonEmpty && (mForce || !claim);
        case (memToReg)
            2'b00:   pdata = Y;
            2'b01:   pdata = rdDataMem;
            2'b10:   pdata = PC_Plus_Immediate;
            default: pdata = '0;
        endcase
        mWe = 1'b0;
        if (claim) begin
            if (pipeRd != 0) begin
                mWe = 1'b1; mAddr = pipeRd; mData = pdata;
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].rd == pipeRd) mq[i].live = 1'b0;
            end
        end else if (pop) begin
            mWe = mq[0].live;
            if (mq[0].live) begin
                mAddr = mq[0].rd; mData = mq[0].data;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{mcuRd, mcuData, (mcuRd != 0)});
        nextForce = !mForce && nonEmpty && !pop && (mWait == MAX_WAIT);
        if (nonEmpty && !pop) mWait = (mWait < MAX_WAIT) ? mWait + 1 : MAX_WAIT;
        else mWait = 0;
        mForce = nextForce;
        @(posedge clk);
        #1;
        checkEq("regWrite", regWrite, mWe);
        checkEq("regWrtAddr", regWrtAddr, mAddr);
        checkEq("regWrtData", regWrtData, mData);
        if (regWrite) dutRf[regWrtAddr] = regWrtData;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waits;
        bit          found;
        logic [4:0]  heldRd;
        logic [4:0]  order [4];

        foreach (dutRf[i]) dutRf[i] = '0;
        pipeValid = 0; pipeRegWrite = 0; pipeRd = 0; memToReg = 0;
        Y = 0; rdDataMem = 0; PC_Plus_Immediate = 0;
        mcuValid = 0; mcuRd = 0; mcuData = 0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkEq("rst_regWrite", regWrite, 0);
        checkEq("rst_regWrtAddr", regWrtAddr, 0);
        checkEq("rst_regWrtData", regWrtData, 0);
        checkEq("rst_stallPipe", stallPipe, 0);
        checkEq("rst_pendBusy", mcuPendBusy, 0);
        checkEq("rst_mcuReady", mcuReady, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Pipeline-only writes
        pipeValid = 1; pipeRegWrite = 1; pipeRd = 5; memToReg = 2'b10;
        PC_Plus_Immediate = 32'h100; Y = 32'h1234; rdDataMem = 32'h5678;
        step();
        checkEq("pcimm_we", regWrite, 1);
        checkEq("pcimm_addr", regWrtAddr, 5);
        checkEq("pcimm_data", regWrtData, 32'h100);
        memToReg = 2'b11; Y = 32'hFFFF_FFFF;
        step();
        checkEq("sel11_zero", regWrtData, 0);
        pipeRd = 0;
        step();
        checkEq("rd0_nowrite", regWrite, 0);

        // Idle-slot drain
        pipeValid = 0;
        mcuValid = 1; mcuRd = 7; mcuData = 32'hDEAD;
        step();
        mcuValid = 0;
        #1 checkEq("pend7_set", mcuPendBusy[7], 1);
        step();
        checkEq("drain_addr", regWrtAddr, 7);
        checkEq("drain_data", regWrtData, 32'hDEAD);
        #1 checkEq("pend7_clr", mcuPendBusy[7], 0);

        // Starvation: pipeline writes every cycle until the forced drain
        pipeValid = 1; pipeRegWrite = 1; memToReg = 2'b00; pipeRd = 1; Y = $urandom;
        mcuValid = 1; mcuRd = 9; mcuData = 32'h9999;
        step();
        mcuValid = 0;
        waits = 0; found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (stallPipe) found = 1;
            else begin
                pipeRd = 5'(1 + c % 8); Y = $urandom;
                step();
                waits++;
            end
        end
        checkEq("force_seen", found, 1);
        checkEq("claims_before_force", waits, MAX_WAIT + 1);
        heldRd = pipeRd;
        step();
        checkEq("force_addr", regWrtAddr, 9);
        checkEq("force_we", regWrite, 1);
        #1 checkEq("force_one_cycle", stallPipe, 0);
        step();
        checkEq("held_write_addr", regWrtAddr, heldRd);

        // WAW kill without a coinciding push
        pipeRd = 1; Y = 32'h1;
        mcuValid = 1; mcuRd = 3; mcuData = 32'hAAAA;
        step();
        mcuValid = 0;
        pipeRd = 3; Y = 32'h11;
        step();
        #1 checkEq("kill_pend3", mcuPendBusy[3], 0);
        pipeValid = 0;
        step();
        checkEq("dead_pop_nowrite", regWrite, 0);
        checkEq("x3_after_kill", dutRf[3], 32'h11);

        // WAW kill with a younger push to the same rd
        pipeValid = 1; pipeRd = 4; Y = $urandom;
        mcuValid = 1; mcuRd = 3; mcuData = 32'h55;
        step();
        pipeRd = 3; Y = 32'h66; mcuRd = 3; mcuData = 32'h77;
        step();
        mcuValid = 0;
        #1 checkEq("young_push_pend3", mcuPendBusy[3], 1);
        pipeValid = 0;
        step();
        step();
        checkEq("x3_young", dutRf[3], 32'h77);

        // Full FIFO, rejected push, simultaneous push/pop, ordering
        pipeValid = 1; pipeRegWrite = 1; pipeRd = 0;
        for (int i = 0; i < 4; i++) begin
            mcuValid = 1; mcuRd = 5'(10 + i); mcuData = 32'hF0 + i;
            step();
        end
        #1 checkEq("full_not_ready", mcuReady, 0);
        mcuRd = 20; mcuData = 32'h20;
        step();
        pipeValid = 0;
        step();
        checkEq("pop_first", regWrtAddr, 10);
        mcuRd = 21; mcuData = 32'h21;
        step();
        checkEq("pop_second", regWrtAddr, 11);
        pipeValid = 1; mcuRd = 22; mcuData = 32'h22;
        step();
        #1 checkEq("refull_not_ready", mcuReady, 0);
        mcuValid = 0; pipeValid = 0;
        order = '{5'd12, 5'd13, 5'd21, 5'd22};
        for (int i = 0; i < 4; i++) begin
            step();
            checkEq("fifo_order", regWrtAddr, order[i]);
        end

        // Randomized traffic; the WB stage re-presents its contents while stalled
        for (int n = 0; n < 3000; n++) begin
            if (!mForce) begin
                pipeValid    = (n < 1500) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                pipeRegWrite = ($urandom_range(0, 4) != 0);
                pipeRd       = 5'($urandom_range(0, 7));
                memToReg     = 2'($urandom);
                Y = $urandom; rdDataMem = $urandom; PC_Plus_Immediate = $urandom;
            end
            mcuValid = ($urandom_range(0, 2) == 0);
            mcuRd    = 5'($urandom_range(0, 7));
            mcuData  = $urandom;
            step();
        end

        // Reset while a forced drain is in progress
        pipeValid = 1; pipeRegWrite = 1; pipeRd = 2; memToReg = 2'b00; Y = 32'h22;
        mcuValid = 1; mcuRd = 6; mcuData = 32'h66;
        step();
        mcuValid = 0;
        for (int c = 0; c < 30 && !stallPipe; c++) step();
        checkEq("force_seen2", stallPipe, 1);
        #2 rst_n = 1'b0;
        #1;
        checkEq("arst_stallPipe", stallPipe, 0);
        checkEq("arst_regWrite", regWrite, 0);
        checkEq("arst_regWrtAddr", regWrtAddr, 0);
        checkEq("arst_regWrtData", regWrtData, 0);
        checkEq("arst_pendBusy", mcuPendBusy, 0);
        checkEq("arst_mcuReady", mcuReady, 1);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        pipeValid = 0;
        repeat (3) begin
            step();
            checkEq("post_rst_nowrite", regWrite, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
